dht11_reader: RTL and testbench

DHT11_READER -- requirements
Module: dht11_reader

---
 rtl/dht11_pkg.sv | 25 ++
 rtl/dht11_tick_gen.sv | 27 ++
 rtl/dht11_reader.sv | 114 +++++++++++
 tb/tb_dht11_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// dht11_pkg: FSM state encoding, error codes, default timing and checksum helper for the DHT11 reader.
package dht11_pkg;
  typedef enum logic [2:0] {
    ST_WAIT,
    ST_START,
    ST_RELEASE,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK
  } state_t;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam int DEF_CLK_FREQ_HZ   = 50_000_000;
  localparam int DEF_POWERUP_MS    = 1000;
  localparam int DEF_PERIOD_MS     = 2000;
  localparam int DEF_START_US      = 18000;
  localparam int DEF_BIT_THRESH_US = 40;
  localparam int DEF_TIMEOUT_US    = 100;
  function automatic logic [7:0] frame_sum(input logic [39:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction
endpackage

// File: rtl/dht11_tick_gen.sv
// dht11_tick_gen: 1 us and 1 ms ticks from CLK_FREQ_HZ; clr realigns both so the clr cycle counts as the first cycle of a new microsecond.
module dht11_tick_gen
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic us_tick,
  output logic ms_tick
);
  localparam int CYC = (CLK_FREQ_HZ < 1_000_000) ? 1 : CLK_FREQ_HZ / 1_000_000;
  localparam logic [15:0] DIV_MAX = 16'(CYC - 1);
  logic [15:0] div_q;
  logic [9:0]  us_q;
  assign us_tick = div_q >= DIV_MAX;
  assign ms_tick = us_tick && us_q == 10'd999;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_q <= 16'd1;
      us_q  <= '0;
    end else begin
      div_q <= clr ? 16'd1 : us_tick ? '0 : div_q + 16'd1;
      us_q  <= clr ? '0 : ms_tick ? '0 : us_tick ? us_q + 10'd1 : us_q;
    end
endmodule

// File: rtl/dht11_reader.sv
// dht11_reader: periodic DHT11 single-wire frame reader with checksum and timeout reporting.
// Define DHT11_FRAC_EN to add the humidity_frac/temperature_frac outputs.
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
  parameter int POWERUP_MS    = DEF_POWERUP_MS,
  parameter int PERIOD_MS     = DEF_PERIOD_MS,
  parameter int START_US      = DEF_START_US,
  parameter int BIT_THRESH_US = DEF_BIT_THRESH_US,
  parameter int TIMEOUT_US    = DEF_TIMEOUT_US
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       data_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
`ifdef DHT11_FRAC_EN
  ,
  output logic [7:0] humidity_frac,
  output logic [7:0] temperature_frac
`endif
);
  localparam logic [15:0] POWERUP_T = 16'(POWERUP_MS);
  localparam logic [15:0] PERIOD_T  = 16'(PERIOD_MS);
  localparam logic [15:0] START_T   = 16'(START_US);
  localparam logic [15:0] TO_T      = 16'(TIMEOUT_US);
  localparam logic [7:0]  THR_T     = 8'(BIT_THRESH_US);
  state_t      state_q, state_d;
  logic        s1, s2, s3, rise, fall;
  logic        us_tick, ms_tick, clr, tick_sel;
  logic [15:0] t_q;
  logic [7:0]  hi_q;
  logic [5:0]  bit_q;
  logic [39:0] sh_q;
  logic        first_q, to, tmo_fire, sum_ok, bit_v;
  dht11_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .us_tick(us_tick),
    .ms_tick(ms_tick)
  );
  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign clr      = state_d != state_q;
  assign tick_sel = (state_q == ST_WAIT) ? ms_tick : us_tick;
  assign bit_v    = hi_q > THR_T;
  assign sum_ok   = frame_sum(sh_q) == sh_q[7:0];
  assign to       = (state_q inside {ST_RELEASE, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH}) && t_q >= TO_T;
  assign tmo_fire = to && state_d == ST_WAIT;
  assign dht_oe   = state_q == ST_START;
  assign busy     = state_q != ST_WAIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_WAIT;
    else state_q <= state_d;
  // A line edge wins over a timeout landing in the same cycle.
  always_comb begin
    state_d = to ? ST_WAIT : state_q;
    case (state_q)
      ST_WAIT:      state_d = (t_q >= (first_q ? POWERUP_T : PERIOD_T)) ? ST_START : ST_WAIT;
      ST_START:     state_d = (t_q >= START_T) ? ST_RELEASE : ST_START;
      ST_RELEASE:   if (fall) state_d = ST_RESP_LOW;
      ST_RESP_LOW:  if (rise) state_d = ST_RESP_HIGH;
      ST_RESP_HIGH: if (fall) state_d = ST_BIT_LOW;
      ST_BIT_LOW:   if (rise) state_d = ST_BIT_HIGH;
      ST_BIT_HIGH:  if (fall) state_d = (bit_q == 6'd39) ? ST_CHECK : ST_BIT_LOW;
      default:      state_d = ST_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      s3          <= 1'b1;
      t_q         <= '0;
      hi_q        <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      first_q     <= 1'b1;
      humidity    <= '0;
      temperature <= '0;
      data_valid  <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
`ifdef DHT11_FRAC_EN
      humidity_frac    <= '0;
      temperature_frac <= '0;
`endif
    end else begin
      s1          <= dht_in;
      s2          <= s1;
      s3          <= s2;
      t_q         <= clr ? '0 : (tick_sel && t_q != 16'hFFFF) ? t_q + 16'd1 : t_q;
      hi_q        <= (state_q == ST_BIT_LOW && rise) ? '0 : (state_q == ST_BIT_HIGH && us_tick && hi_q != 8'hFF) ? hi_q + 8'd1 : hi_q;
      bit_q       <= (state_q == ST_START) ? '0 : (state_q == ST_BIT_HIGH && fall) ? bit_q + 6'd1 : bit_q;
      sh_q        <= (state_q == ST_START) ? '0 : (state_q == ST_BIT_HIGH && fall) ? {sh_q[38:0], bit_v} : sh_q;
      first_q     <= first_q && state_d == ST_WAIT;
      data_valid  <= state_q == ST_CHECK && sum_ok;
      err         <= (state_q == ST_CHECK && !sum_ok) || tmo_fire;
      err_code    <= (state_q == ST_CHECK) ? (sum_ok ? ERR_NONE : ERR_CHECKSUM) : tmo_fire ? ERR_TIMEOUT : err_code;
      humidity    <= (state_q == ST_CHECK && sum_ok) ? sh_q[39:32] : humidity;
      temperature <= (state_q == ST_CHECK && sum_ok) ? sh_q[23:16] : temperature;
`ifdef DHT11_FRAC_EN
      humidity_frac    <= (state_q == ST_CHECK && sum_ok) ? sh_q[31:24] : humidity_frac;
      temperature_frac <= (state_q == ST_CHECK && sum_ok) ? sh_q[15:8] : temperature_frac;
`endif
    end
endmodule

// File: tb/tb_dht11_reader.sv
// tb_dht11_reader: directed DHT11 sensor model driving frames, silence, slow bits and a mid-START reset.
module tb_dht11_reader;
  localparam int TO_US = 100;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_low = 1'b0;
  logic       dht_in, dht_oe, data_valid, err, busy;
  logic [7:0] humidity, temperature;
  logic [1:0] err_code;
`ifdef DHT11_FRAC_EN
  logic [7:0] humidity_frac, temperature_frac;
`endif
  int         checks = 0;
  int         errors = 0;
  int         dv_n = 0;
  int         err_n = 0;
  int         both_n = 0;
  logic [1:0] ec_last = 2'd0;
  assign dht_in = ~(dht_oe | sensor_low);
  always #5 clk = ~clk;
  dht11_reader #(
    .CLK_FREQ_HZ  (2_000_000),
    .POWERUP_MS   (1),
    .PERIOD_MS    (2),
    .START_US     (200),
    .BIT_THRESH_US(40),
    .TIMEOUT_US   (TO_US)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .humidity   (humidity),
    .temperature(temperature),
    .data_valid (data_valid),
    .err        (err),
    .err_code   (err_code),
    .busy       (busy)
`ifdef DHT11_FRAC_EN
    ,
    .humidity_frac   (humidity_frac),
    .temperature_frac(temperature_frac)
`endif
  );
  always @(negedge clk) begin
    if (data_valid) dv_n++;
    if (err) begin
      err_n++;
      ec_last = err_code;
    end
    if (data_valid && err) both_n++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert ((v >= lo && v <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask
  task automatic wait_us(input int n);
    repeat (2 * n) @(negedge clk);
  endtask
  task automatic wait_start(output int pre, output int len);
    pre = 0;
    len = 0;
    while (!dht_oe && pre < 9000) begin
      @(negedge clk);
      pre++;
    end
    while (dht_oe && len < 2000) begin
      @(negedge clk);
      len++;
    end
  endtask
  task automatic respond(input logic [39:0] f, input int h0, input int h1);
    wait_us(30);
    sensor_low = 1'b1;
    wait_us(80);
    sensor_low = 1'b0;
    wait_us(80);
    for (int i = 39; i >= 0; i--) begin
      int h;
      h = f[i] ? h1 : h0;
      sensor_low = 1'b1;
      wait_us(50);
      sensor_low = 1'b0;
      wait_us(h);
      if (h > TO_US) break;
    end
    sensor_low = 1'b1;
    wait_us(50);
    sensor_low = 1'b0;
    repeat (10) @(negedge clk);
  endtask
  initial begin
    repeat (400000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int pre, len, dv0, er0, n;
    repeat (3) @(negedge clk);
    chk("rst_oe", dht_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ec", err_code, 0);
    chk("rst_hum", humidity, 0);
    chk("rst_temp", temperature, 0);
    rst_n = 1'b1;
    wait_start(pre, len);
    chk_rng("powerup_gap", pre, 1995, 2005);
    chk("start_len", len, 400);
    dv0 = dv_n;
    er0 = err_n;
    respond(40'h37_00_19_00_50, 26, 70);
    chk("good_dv", dv_n - dv0, 1);
    chk("good_err", err_n - er0, 0);
    chk("good_hum", humidity, 55);
    chk("good_temp", temperature, 25);
    chk("good_ec", err_code, 0);
    wait_start(pre, len);
    dv0 = dv_n;
    er0 = err_n;
    respond(40'h37_00_19_00_51, 26, 70);
    chk("sum_err", err_n - er0, 1);
    chk("sum_dv", dv_n - dv0, 0);
    chk("sum_ec_pulse", ec_last, 2);
    chk("sum_ec_hold", err_code, 2);
    chk("sum_hum", humidity, 55);
    chk("sum_temp", temperature, 25);
    wait_start(pre, len);
    n = 0;
    while (!err && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk_rng("silent_to", n, 198, 202);
    chk("silent_ec", err_code, 1);
    wait_start(pre, len);
    chk_rng("period_gap", pre, 3995, 4005);
    dv0 = dv_n;
    respond(40'h2A_00_14_00_3E, 39, 41);
    chk("thr_dv", dv_n - dv0, 1);
    chk("thr_hum", humidity, 42);
    chk("thr_temp", temperature, 20);
    chk("thr_ec", err_code, 0);
    wait_start(pre, len);
    er0 = err_n;
    respond(40'h37_00_19_00_50, 26, 120);
    chk("long_err", err_n - er0, 1);
    chk("long_ec", ec_last, 1);
    chk("long_hum", humidity, 42);
    chk("long_temp", temperature, 20);
    wait_start(pre, len);
    dv0 = dv_n;
    respond(40'h37_05_19_03_58, 26, 70);
    chk("frac_dv", dv_n - dv0, 1);
    chk("frac_hum", humidity, 55);
    chk("frac_temp", temperature, 25);
`ifdef DHT11_FRAC_EN
    chk("frac_hf", humidity_frac, 5);
    chk("frac_tf", temperature_frac, 3);
`endif
    n = 0;
    while (!dht_oe && n < 9000) begin
      @(negedge clk);
      n++;
    end
    wait_us(100);
    rst_n = 1'b0;
    #1;
    chk("arst_oe", dht_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_hum", humidity, 0);
    chk("arst_ec", err_code, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_start(pre, len);
    chk_rng("repower_gap", pre, 1995, 2005);
    chk("dv_err_overlap", both_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
